// File: rtl/imem_arbiter_if.sv
// Bundles the loader, fetch, memory and status signals of the instruction-memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface imem_arbiter_if #(
  parameter int AW = 7
);
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_inst;
  logic          fetch_valid;
  logic          cpu_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [AW:0]   load_count;
  logic [1:0]    state;

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done, fetch_req, fetch_pc, mem_rdata,
    output ld_ready, fetch_inst, fetch_valid, cpu_stall, mem_we, mem_addr, mem_wdata,
           load_count, state
  );

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done, fetch_req, fetch_pc, mem_rdata,
    input  ld_ready, fetch_inst, fetch_valid, cpu_stall, mem_we, mem_addr, mem_wdata,
           load_count, state
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port instruction memory between a boot loader and the CPU fetch path.
// Boot phase gives the loader exclusive access; in RUN contention alternates fetch/loader.
module imem_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // 1'b0 = loader, 1'b1 = fetch
  logic          fv_q;
  logic          oob_q;
  logic [31:0]   inst_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [AW:0]   count_q;

  logic          wr_grant;
  logic          fetch_grant;
  logic          oob;
  logic          stall;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   mem_wdata_s;
  logic [31:0]   fetch_inst_s;

  assign oob = (bus.fetch_pc >= 32'(DEPTH));

  // Next-state, grant and stall decode; reset suppresses every grant in the same cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_grant     = 1'b0;
    fetch_grant  = 1'b0;
    stall        = 1'b1;
    case (state_q)
      IDLE: begin
        wr_grant = bus.ld_valid;
        if (bus.ld_valid) begin
          state_d = LOAD;
        end else if (bus.ld_done) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        wr_grant = bus.ld_valid;
        if (bus.ld_done) begin
          state_d = RUN;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (bus.fetch_req && bus.ld_valid) begin
          fetch_grant  = ~last_grant_q;
          wr_grant     = last_grant_q;
          last_grant_d = ~last_grant_q;
        end else begin
          fetch_grant = bus.fetch_req;
          wr_grant    = bus.ld_valid;
        end
        stall = bus.fetch_req & ~fetch_grant;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      wr_grant    = 1'b0;
      fetch_grant = 1'b0;
    end else begin
      wr_grant    = wr_grant;
      fetch_grant = fetch_grant;
    end
  end

  // Memory address/data mux; an out-of-range fetch leaves the held address on the bus.
  always_comb begin
    mem_addr_s  = addr_q;
    mem_wdata_s = wdata_q;
    if (rst) begin
      mem_addr_s  = '0;
      mem_wdata_s = 32'h0000_0000;
    end else if (wr_grant) begin
      mem_addr_s  = bus.ld_addr;
      mem_wdata_s = bus.ld_data;
    end else if (fetch_grant && !oob) begin
      mem_addr_s  = bus.fetch_pc[AW-1:0];
    end else begin
      mem_addr_s  = addr_q;
    end
  end

  // Fetch response: live memory data (or NOP) when valid, otherwise the last delivered word.
  always_comb begin
    fetch_inst_s = inst_q;
    if (fv_q) begin
      fetch_inst_s = oob_q ? 32'h0000_0000 : bus.mem_rdata;
    end else begin
      fetch_inst_s = inst_q;
    end
  end

  // State, arbitration history, fetch pipeline and held bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      fv_q         <= 1'b0;
      oob_q        <= 1'b0;
      inst_q       <= 32'h0000_0000;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fv_q         <= fetch_grant;
      oob_q        <= oob;
      inst_q       <= fetch_inst_s;
      addr_q       <= mem_addr_s;
      wdata_q      <= mem_wdata_s;
      if (wr_grant && (count_q < DEPTH_C)) begin
        count_q <= count_q + (AW+1)'(1);
      end else begin
        count_q <= count_q;
      end
    end
  end

  assign bus.mem_we      = wr_grant;
  assign bus.ld_ready    = wr_grant;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.cpu_stall   = stall;
  assign bus.fetch_valid = fv_q;
  assign bus.fetch_inst  = fetch_inst_s;
  assign bus.load_count  = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: fetch responses go through an expected-value queue
// checked by a monitor; bus, stall and status outputs are checked per cycle.
module tb_imem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:127];

  imem_arbiter_if #(.AW(7)) bus ();

  imem_arbiter #(.DEPTH(128), .AW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port memory with one cycle read latency.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fetch_valid cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch_valid inst=%h t=%0t", bus.fetch_inst, $time);
      end else begin
        chk("fetch_inst", bus.fetch_inst, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic drive(input logic r, input logic lv, input logic [6:0] la, input logic [31:0] ldat,
                       input logic ldd, input logic fr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst           = r;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.ld_data   = ldat;
    bus.ld_done   = ldd;
    bus.fetch_req = fr;
    bus.fetch_pc  = pc;
    #3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_addr = 7'd0; bus.ld_data = 32'd0;
    bus.ld_done = 1'b0; bus.fetch_req = 1'b0; bus.fetch_pc = 32'd0;

    // Reset state, and a write coincident with reset is discarded.
    drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_load_count", 32'(bus.load_count), 32'd0);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_inst", bus.fetch_inst, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd1);
    drive(1'b1, 1'b1, 7'd9, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    chk("rst_write_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_write_ld_ready", 32'(bus.ld_ready), 32'd0);

    // Boot load; fetch requests during LOAD stay stalled.
    drive(1'b0, 1'b1, 7'd0, 32'h0000_0001, 1'b0, 1'b0, 32'd0);
    chk("idle_write_we", 32'(bus.mem_we), 32'd1);
    chk("idle_write_ready", 32'(bus.ld_ready), 32'd1);
    chk("idle_write_addr", 32'(bus.mem_addr), 32'd0);
    chk("idle_write_data", bus.mem_wdata, 32'h0000_0001);
    chk("idle_state", 32'(bus.state), 32'd0);
    drive(1'b0, 1'b1, 7'd1, 32'h0000_0002, 1'b0, 1'b1, 32'd1);
    chk("load_state", 32'(bus.state), 32'd1);
    chk("load_stall", 32'(bus.cpu_stall), 32'd1);
    chk("load_addr", 32'(bus.mem_addr), 32'd1);
    chk("load_count1", 32'(bus.load_count), 32'd1);
    drive(1'b0, 1'b1, 7'd2, 32'h0000_0003, 1'b0, 1'b1, 32'd1);
    chk("load_stall2", 32'(bus.cpu_stall), 32'd1);
    chk("load_we2", 32'(bus.mem_we), 32'd1);
    chk("load_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    drive(1'b0, 1'b1, 7'd3, 32'h0000_0004, 1'b1, 1'b0, 32'd0);
    chk("done_write_ready", 32'(bus.ld_ready), 32'd1);
    chk("done_write_addr", 32'(bus.mem_addr), 32'd3);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("boot_state_run", 32'(bus.state), 32'd2);
    chk("boot_load_count", 32'(bus.load_count), 32'd4);
    chk("run_no_req_stall", 32'(bus.cpu_stall), 32'd0);
    chk("nogrant_we", 32'(bus.mem_we), 32'd0);
    chk("nogrant_addr_hold", 32'(bus.mem_addr), 32'd3);
    chk("nogrant_wdata_hold", bus.mem_wdata, 32'h0000_0004);

    // Contention: F, L, F, L.
    drive(1'b0, 1'b1, 7'd10, 32'hA0A0_0010, 1'b0, 1'b1, 32'd1);
    exp_q.push_back(32'h0000_0002);
    chk("cont1_we", 32'(bus.mem_we), 32'd0);
    chk("cont1_addr", 32'(bus.mem_addr), 32'd1);
    chk("cont1_stall", 32'(bus.cpu_stall), 32'd0);
    chk("cont1_ready", 32'(bus.ld_ready), 32'd0);
    drive(1'b0, 1'b1, 7'd10, 32'hA0A0_0010, 1'b0, 1'b1, 32'd3);
    chk("cont2_we", 32'(bus.mem_we), 32'd1);
    chk("cont2_addr", 32'(bus.mem_addr), 32'd10);
    chk("cont2_stall", 32'(bus.cpu_stall), 32'd1);
    chk("cont2_ready", 32'(bus.ld_ready), 32'd1);
    drive(1'b0, 1'b1, 7'd11, 32'hB0B0_0011, 1'b0, 1'b1, 32'd3);
    exp_q.push_back(32'h0000_0004);
    chk("cont3_we", 32'(bus.mem_we), 32'd0);
    chk("cont3_addr", 32'(bus.mem_addr), 32'd3);
    chk("cont3_stall", 32'(bus.cpu_stall), 32'd0);
    chk("cont3_ready", 32'(bus.ld_ready), 32'd0);
    drive(1'b0, 1'b1, 7'd11, 32'hB0B0_0011, 1'b0, 1'b1, 32'd2);
    chk("cont4_we", 32'(bus.mem_we), 32'd1);
    chk("cont4_addr", 32'(bus.mem_addr), 32'd11);
    chk("cont4_stall", 32'(bus.cpu_stall), 32'd1);
    chk("cont4_ready", 32'(bus.ld_ready), 32'd1);

    // Plain fetches, including the words written under contention.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd2);
    exp_q.push_back(32'h0000_0003);
    chk("fetch_we", 32'(bus.mem_we), 32'd0);
    chk("fetch_addr", 32'(bus.mem_addr), 32'd2);
    chk("fetch_stall", 32'(bus.cpu_stall), 32'd0);
    chk("cont_load_count", 32'(bus.load_count), 32'd6);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd10);
    exp_q.push_back(32'hA0A0_0010);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd11);
    exp_q.push_back(32'hB0B0_0011);

    // Out-of-range fetch returns a NOP and leaves mem_addr alone.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd200);
    exp_q.push_back(32'h0000_0000);
    chk("oob_we", 32'(bus.mem_we), 32'd0);
    chk("oob_addr_hold", 32'(bus.mem_addr), 32'd11);
    chk("oob_stall", 32'(bus.cpu_stall), 32'd0);

    // Loader alone in RUN, then fetch its word back.
    drive(1'b0, 1'b1, 7'd5, 32'h5555_0005, 1'b0, 1'b0, 32'd0);
    chk("run_write_ready", 32'(bus.ld_ready), 32'd1);
    chk("run_write_addr", 32'(bus.mem_addr), 32'd5);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd5);
    exp_q.push_back(32'h5555_0005);
    chk("run_load_count", 32'(bus.load_count), 32'd7);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("hold_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("hold_fetch_inst", bus.fetch_inst, 32'h5555_0005);

    // Reset during a fetch drops the response.
    drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    chk("rstfetch_we", 32'(bus.mem_we), 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rstfetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rstfetch_state", 32'(bus.state), 32'd0);
    chk("rstfetch_count", 32'(bus.load_count), 32'd0);

    // IDLE straight to RUN on ld_done.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("idle_done_run", 32'(bus.state), 32'd2);

    // Saturating load_count after 130 writes.
    drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 130; i++) begin
      drive(1'b0, 1'b1, 7'(i), 32'h0000_1000 + 32'(i), 1'b0, 1'b0, 32'd0);
      if (i == 127) chk("count_127", 32'(bus.load_count), 32'd127);
    end
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("count_saturated", 32'(bus.load_count), 32'd128);
    chk("sat_state_load", 32'(bus.state), 32'd1);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd127);
    exp_q.push_back(32'h0000_107F);
    chk("sat_state_run", 32'(bus.state), 32'd2);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd128);
    exp_q.push_back(32'h0000_0000);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    exp_q.push_back(32'h0000_1080);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning number of 32-bit instruction words.
REQ-002 SHALL have parameter AW, default 7, meaning word-address width (2^AW = DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ld_valid  input  1  loader write request.
REQ-006 SHALL have port ld_addr  input  AW  loader word address.
REQ-007 SHALL have port ld_data  input  32  loader instruction word.
REQ-008 SHALL have port ld_ready  output  1  loader write accepted this cycle.
REQ-009 SHALL have port ld_done  input  1  loader finished; one-cycle pulse.
REQ-010 SHALL have port fetch_req  input  1  processor fetch request.
REQ-011 SHALL have port fetch_pc  input  32  fetch word index, not byte address.
REQ-012 SHALL have port fetch_inst  output  32  fetched instruction.
REQ-013 SHALL have port fetch_valid  output  1  fetch_inst valid this cycle.
REQ-014 SHALL have port cpu_stall  output  1  processor must hold PC.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_addr  output  AW  memory word address.
REQ-017 SHALL have port mem_wdata  output  32  memory write data.
REQ-018 SHALL have port mem_rdata  input  32  memory read data, one cycle after mem_addr presented.
REQ-019 SHALL have port load_count  output  AW+1  words written since reset, saturating at DEPTH.
REQ-020 SHALL have port state  output  2  current FSM state code.

Function
REQ-021 SHALL implement the FSM states IDLE=0, LOAD=1, RUN=2.
REQ-022 IDLE SHALL go to LOAD on ld_valid, and SHALL go directly to RUN on ld_done with ld_valid low.
REQ-023 LOAD SHALL go to RUN on ld_done; a ld_valid in the same cycle as ld_done SHALL be accepted before the transition.
REQ-024 RUN SHALL remain in RUN until rst.
REQ-025 In IDLE/LOAD: ld_ready=ld_valid, fetch grants=0, cpu_stall=1, fetch_valid=0.
REQ-026 In IDLE, an accepted ld_valid SHALL perform its write in the same cycle.
REQ-027 In RUN, fetch_req alone SHALL be granted.
REQ-028 In RUN, ld_valid alone SHALL be granted.
REQ-029 In RUN, when fetch_req and ld_valid both assert, the grant SHALL alternate, tracked by a last_grant flag.
REQ-030 last_grant SHALL reset to "loader", so the first contention cycle grants fetch.
REQ-031 Write grant SHALL drive, combinationally in the same cycle: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_ready=1.
REQ-032 Fetch grant SHALL drive, combinationally in the same cycle: mem_we=0, mem_addr=fetch_pc[AW-1:0].
REQ-033 A fetch granted in cycle N SHALL give fetch_valid=1 and fetch_inst=mem_rdata in cycle N+1 (latency 1).
REQ-034 A fetch with fetch_pc >= DEPTH SHALL be granted, SHALL not drive mem_addr, and SHALL return fetch_inst=0 (NOP) with fetch_valid=1 at N+1.
REQ-035 fetch_inst SHALL hold its last value when fetch_valid=0.
REQ-036 cpu_stall SHALL be 1 in RUN whenever fetch_req=1 and the fetch is not granted; otherwise 0 in RUN.
REQ-037 ld_ready SHALL be 0 whenever ld_valid=0.
REQ-038 A loader write with ld_valid held SHALL complete once; the loader SHALL deassert ld_valid or present a new word after ld_ready.
REQ-039 load_count SHALL increment on every accepted write, in any state, and SHALL saturate at DEPTH.
REQ-040 With no grant: mem_we=0; mem_addr and mem_wdata SHALL hold their previous values.

Reset
REQ-041 On rst the FSM SHALL go to IDLE.
REQ-042 On rst: fetch_valid=0, fetch_inst=0, load_count=0, last_grant=loader, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-043 rst mid-operation SHALL drop any pending fetch response (no fetch_valid the cycle after rst).
REQ-044 rst mid-operation SHALL discard a coincident write (mem_we=0 while rst=1).

Verification
REQ-045 Boot load: after rst, write addr 0..3 with 0x01..0x04, then pulse ld_done -> load_count=4, state=RUN, cpu_stall=0 with fetch_req low.
REQ-046 Fetch latency: RUN, fetch_pc=2 at cycle N -> fetch_valid=1, fetch_inst=0x03 at N+1, mem_we=0 at N.
REQ-047 Contention: RUN, fetch_req and ld_valid both high for 4 cycles -> grants F,L,F,L; cpu_stall=1 in cycles 2 and 4; ld_ready=1 in cycles 2 and 4.
REQ-048 Out of range: fetch_pc=200 -> fetch_inst=0x00000000, fetch_valid=1 next cycle, mem_we=0.
REQ-049 Fetch during load: state LOAD, fetch_req=1 -> cpu_stall=1, fetch_valid=0, writes proceed every cycle.
REQ-050 Reset mid-fetch: fetch granted at N, rst=1 at N -> fetch_valid=0 at N+1, state=IDLE, load_count=0.
